const_encoder_param: RTL and testbench
======================================

// Module: const_encoder_param
// PURPOSE
//  Parametrised DMT constellation encoder: consumes a serial bit stream as DW-bit words and splits it per bin
//  according to a programmable bit-loading table (b bits per bin). Maps each bin's bits to signed QAM (x,y).
//  Sits between the tone-ordering buffer and the IFFT input formatter. Adds valid/ack output backpressure
//  and a symbol-done strobe.
// PARAMETERS
//  NUM_BINS  256  bins per DMT symbol; AW = $clog2(NUM_BINS)
//  MAX_B     14   max bits per bin (even, <=15)
//  BW        4    bit-loading entry width
//  DW        16   input data word width
//  XYW       9    signed x/y output width; XYW >= MAX_B/2+1
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous, active-high reset
//  en_i         in   1    1 = encode; 0 = idle/flush
//  we_conf_i    in   1    bit-loading table write strobe
//  conf_addr_i  in   AW   table bin address
//  conf_data_i  in   BW   bits for that bin
//  input_ready_o out 1    buffer can accept one DW word this cycle
//  we_data_i    in   1    data word write strobe
//  data_i       in   DW   data word, LSB consumed first
//  xy_ready_o   out  1    x_o/y_o/bin_num_o valid
//  xy_ack_i     in   1    consumer accepts current point
//  bin_num_o    out  AW   bin index of current point
//  x_o, y_o     out  XYW  signed constellation coordinates
//  sym_done_o   out  1    1-cycle pulse when bin NUM_BINS-1 is retired
// BEHAVIOUR
//  Reset: xy_ready_o=0, sym_done_o=0, x_o=y_o=0, bin_num_o=0, bit buffer empty, input_ready_o=1, FSM=IDLE.
//   Table is not reset; program it before en_i=1.
//  Table writes accepted only while en_i=0; ignored when en_i=1 or conf_data_i>MAX_B or odd (see CONFIGURATION).
//  Bit buffer: BUF_W=DW+MAX_B bits, count bit_cnt. input_ready_o = (bit_cnt <= BUF_W-DW), from registered count.
//   we_data_i with input_ready_o=0 is dropped. A word is appended above the existing bits.
//  FSM:
//   IDLE  -> FETCH when en_i=1.
//   FETCH -> read table[bin_cnt] (sync RAM, 1 cycle) -> CHECK.
//   CHECK -> b==0: advance bin, FETCH; no output.
//            b<=bit_cnt: pop b LSBs v[b-1:0], register x/y, xy_ready_o<=1, HOLD.
//            otherwise: stay in CHECK.
//   HOLD  -> outputs held stable. On xy_ack_i: xy_ready_o<=0, advance bin, FETCH.
//  Advance: bin_cnt==NUM_BINS-1 -> 0 and sym_done_o=1 for one cycle; else +1.
//  Push and pop in the same cycle: pop taken from old LSBs, word appended at bit_cnt-b; no bit lost.
//  Even b mapping (two's complement, sign-extended to XYW):
//   x = {v[b-1],v[b-3],...,v[1],1'b1}; y = {v[b-2],...,v[0],1'b1}.
//  Latency: the point is valid 1 cycle after CHECK sees enough bits. Min 3 cycles per point with xy_ack_i held high.
//  en_i=0 in any state: next edge FSM=IDLE, bin_cnt=0, buffer flushed, xy_ready_o=0, pending point discarded,
//   no sym_done_o.
//  Reset mid-operation: identical to the reset values above.
// CONFIGURATION
//  CONST_ENC_ODD_B_EN defined: b=1 and b=3 are accepted.
//   b=1: x=y={v0,1} (v0=0 -> (1,1), v0=1 -> (-1,-1)).
//   b=3: x={v2,v1,1}, y={v2,v0,1}.
//   Odd b>=5 writes are still ignored.
//  Not defined: all odd-b writes are ignored; mapper holds even-b logic only.
// TESTING
//  1 bins0..3 = 2,0,4,0, rest 0; data_i=16'h00B3 -> (bin0,x=-1,y=-1), then (bin2,x=-3,y=-3); bin1 emits nothing.
//  2 hold xy_ack_i=0 for 5 cycles on bin0 point -> x_o/y_o/bin_num_o stable, xy_ready_o=1, bit_cnt unchanged.
//  3 NUM_BINS=4, all b=2, 2 words -> bin_num 0,1,2,3,0,...; sym_done_o pulses once after the bin3 ack.
//  4 en_i=0 while in HOLD at bin2 -> next cycle xy_ready_o=0, input_ready_o=1; re-enable restarts at bin0.
//  5 write 5 to bin0 -> table unchanged. With CONST_ENC_ODD_B_EN: b=3, v=3'b101 -> x=-3,y=-1; b=1, v=1 -> (-1,-1).
//  6 b=14, data all ones -> x=y=-1; data 16'h0000 -> x=y=+1; buffer refill with simultaneous push/pop keeps stream order.

Source files
------------

// File: rtl/const_encoder_param.sv
// DMT constellation encoder: splits a DW-bit word stream into per-bin bit groups from a bit-loading table and maps each group to signed QAM (x,y).
// Latency: point valid 1 cycle after CHECK has enough bits (min 3 cycles/point); holds point until xy_ack_i; input_ready_o drops when the buffer cannot take a word.
// Optional odd loading (b=1,3) enabled by defining CONST_ENC_ODD_B_EN.
module const_encoder_param #(
   parameter int NUM_BINS = 256,
   parameter int MAX_B    = 14,
   parameter int BW       = 4,
   parameter int DW       = 16,
   parameter int XYW      = 9,
   localparam int AW      = $clog2(NUM_BINS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en_i,
   input  logic                  we_conf_i,
   input  logic [AW-1:0]         conf_addr_i,
   input  logic [BW-1:0]         conf_data_i,
   output logic                  input_ready_o,
   input  logic                  we_data_i,
   input  logic [DW-1:0]         data_i,
   output logic                  xy_ready_o,
   input  logic                  xy_ack_i,
   output logic [AW-1:0]         bin_num_o,
   output logic signed [XYW-1:0] x_o,
   output logic signed [XYW-1:0] y_o,
   output logic                  sym_done_o
);

   localparam int BUF_W = DW + MAX_B;
   localparam int CW    = $clog2(BUF_W + 1);
   localparam int VW    = 1 << BW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [BW-1:0]    tbl [NUM_BINS];
   logic [BW-1:0]    b_q;
   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    bin_cnt_q, bin_cnt_d;
   logic [BUF_W-1:0] buf_q, buf_d, shifted;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_after;
   logic [XYW-1:0]   x_q, x_d, y_q, y_d, map_x, map_y;
   logic             rdy_q, rdy_d, done_q, done_d;
   logic             conf_ok, push, pop, advance;
   logic [VW-1:0]    v;
   logic [BW-1:0]    b_m1, b_m2, nbits;
   logic             x_sgn, y_sgn;

   always_comb begin
      conf_ok = (conf_data_i <= BW'(MAX_B)) && !conf_data_i[0];
`ifdef CONST_ENC_ODD_B_EN
      if (conf_data_i == BW'(1) || conf_data_i == BW'(3)) conf_ok = 1'b1;
`endif
   end

   // Table is deliberately not reset; the read port runs every cycle.
   always_ff @(posedge clk) begin
      if (we_conf_i && !en_i && conf_ok) tbl[conf_addr_i] <= conf_data_i;
      b_q <= tbl[bin_cnt_q];
   end

   assign input_ready_o = (cnt_q <= CW'(BUF_W - DW));
   assign push          = we_data_i && input_ready_o;

   always_comb begin
      v            = '0;
      v[MAX_B-1:0] = buf_q[MAX_B-1:0];
      b_m1         = b_q - BW'(1);
      b_m2         = b_q - BW'(2);
      nbits        = b_q >> 1;
      x_sgn        = v[b_m1];
`ifdef CONST_ENC_ODD_B_EN
      y_sgn        = b_q[0] ? v[b_m1] : v[b_m2];
`else
      y_sgn        = v[b_m2];
`endif
      map_x = '0;
      map_y = '0;
      for (int k = 0; k < XYW; k++) begin
         if (k == 0) begin
            map_x[k] = 1'b1;
            map_y[k] = 1'b1;
         end else if (k <= int'(nbits)) begin
            map_x[k] = v[BW'(2*k-1)];
            map_y[k] = v[BW'(2*k-2)];
         end else begin
            map_x[k] = x_sgn;
            map_y[k] = y_sgn;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bin_cnt_d = bin_cnt_q;
      rdy_d     = rdy_q;
      done_d    = 1'b0;
      x_d       = x_q;
      y_d       = y_q;
      pop       = 1'b0;
      advance   = 1'b0;
      case (state_q)
         S_IDLE:  if (en_i) state_d = S_FETCH;
         S_FETCH: state_d = S_CHECK;
         S_CHECK: begin
            if (b_q == '0) begin
               advance = 1'b1;
            end else if (CW'(b_q) <= cnt_q) begin
               pop     = 1'b1;
               x_d     = map_x;
               y_d     = map_y;
               rdy_d   = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (xy_ack_i) begin
               rdy_d   = 1'b0;
               advance = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         state_d = S_FETCH;
         if (bin_cnt_q == AW'(NUM_BINS - 1)) begin
            bin_cnt_d = '0;
            done_d    = 1'b1;
         end else begin
            bin_cnt_d = bin_cnt_q + AW'(1);
         end
      end

      // Pop uses the old LSBs; a same-cycle word lands right above what remains.
      shifted   = pop ? (buf_q >> b_q) : buf_q;
      cnt_after = cnt_q - (pop ? CW'(b_q) : CW'(0));
      buf_d     = shifted;
      cnt_d     = cnt_after;
      if (push) begin
         buf_d = shifted | (BUF_W'(data_i) << cnt_after);
         cnt_d = cnt_after + CW'(DW);
      end

      if (!en_i) begin
         state_d   = S_IDLE;
         bin_cnt_d = '0;
         buf_d     = '0;
         cnt_d     = '0;
         rdy_d     = 1'b0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bin_cnt_q <= '0;
         buf_q     <= '0;
         cnt_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         rdy_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_cnt_q <= bin_cnt_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         rdy_q     <= rdy_d;
         done_q    <= done_d;
      end
   end

   assign xy_ready_o = rdy_q;
   assign bin_num_o  = bin_cnt_q;
   assign x_o        = x_q;
   assign y_o        = y_q;
   assign sym_done_o = done_q;

endmodule

// File: tb/tb_const_encoder_param.sv
// Directed bench for const_encoder_param: table-driven mapping vectors plus hand sequences on a 256-bin and a 4-bin instance.
module tb_const_encoder_param;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 256-bin instance
   logic              en, we_conf, we_data, ack;
   logic [7:0]        conf_addr;
   logic [3:0]        conf_data;
   logic [15:0]       data;
   logic              in_rdy, xy_rdy, sd;
   logic [7:0]        bin_num;
   logic signed [8:0] x, y;

   // 4-bin instance
   logic              s_en, s_we_conf, s_we_data, s_ack;
   logic [1:0]        s_conf_addr;
   logic [3:0]        s_conf_data;
   logic [15:0]       s_data;
   logic              s_in_rdy, s_xy_rdy, s_sd;
   logic [1:0]        s_bin_num;
   logic signed [8:0] s_x, s_y;

   const_encoder_param dut (
      .clk(clk), .reset(reset), .en_i(en), .we_conf_i(we_conf), .conf_addr_i(conf_addr),
      .conf_data_i(conf_data), .input_ready_o(in_rdy), .we_data_i(we_data), .data_i(data),
      .xy_ready_o(xy_rdy), .xy_ack_i(ack), .bin_num_o(bin_num), .x_o(x), .y_o(y), .sym_done_o(sd)
   );

   const_encoder_param #(.NUM_BINS(4)) u_small (
      .clk(clk), .reset(reset), .en_i(s_en), .we_conf_i(s_we_conf), .conf_addr_i(s_conf_addr),
      .conf_data_i(s_conf_data), .input_ready_o(s_in_rdy), .we_data_i(s_we_data), .data_i(s_data),
      .xy_ready_o(s_xy_rdy), .xy_ack_i(s_ack), .bin_num_o(s_bin_num), .x_o(s_x), .y_o(s_y), .sym_done_o(s_sd)
   );

   int n_tot = 0;
   int n_pass = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          b;
      logic [15:0] d;
      int          ex;
      int          ey;
   } vec_t;
   vec_t vt[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic wcfg(input int a, input int d);
      en = 1'b0; we_conf = 1'b1; conf_addr = a[7:0]; conf_data = d[3:0];
      tick();
      we_conf = 1'b0;
   endtask

   task automatic wait_pt(output int waited);
      waited = 0;
      while (!xy_rdy && waited < 40) begin
         tick();
         waited++;
      end
      if (!xy_rdy) chk("point_timeout", 0, 1);
   endtask

   task automatic push_word(input logic [15:0] w);
      we_data = 1'b1; data = w;
      tick();
      we_data = 1'b0;
   endtask

   initial begin
      int w, bad, n, sd_bad, sd_seen, t_first, t_last, since_pt;
      bit pend_sd, words_left;
      logic [31:0] stream;
      logic v0, v1;

      reset = 1'b1; en = 0; we_conf = 0; we_data = 0; ack = 0; conf_addr = 0; conf_data = 0; data = 0;
      s_en = 0; s_we_conf = 0; s_we_data = 0; s_ack = 0; s_conf_addr = 0; s_conf_data = 0; s_data = 0;
      tick(); tick();
      chk("rst_xy_ready", xy_rdy, 0);
      chk("rst_sym_done", sd, 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_bin", bin_num, 0);
      chk("rst_in_ready", in_rdy, 1);
      chk("rst_small_ready", s_xy_rdy, 0);
      reset = 1'b0;

      for (int i = 0; i < 256; i++) wcfg(i, 0);

      vt[0]  = '{2,  16'h0003, -1, -1};
      vt[1]  = '{2,  16'h0000,  1,  1};
      vt[2]  = '{2,  16'h0001,  1, -1};
      vt[3]  = '{4,  16'h000C, -3, -3};
      vt[4]  = '{4,  16'h0005,  1, -1};
      vt[5]  = '{6,  16'h002A, -1,  1};
      vt[6]  = '{8,  16'h00A5, -7,  7};
      vt[7]  = '{14, 16'hFFFF, -1, -1};
      vt[8]  = '{14, 16'h0000,  1,  1};
      vt[9]  = '{14, 16'h2000, -127, 1};
      vt[10] = '{2,  16'h0003, -1, -1};
      vt[11] = '{5,  16'h0001,  1, -1};
      vt[12] = '{15, 16'h0001,  1, -1};
`ifdef CONST_ENC_ODD_B_EN
      vt[13] = '{3,  16'h0005, -3, -1};
      vt[14] = '{1,  16'h0001, -1, -1};
`else
      vt[13] = '{3,  16'h0005,  1, -1};
      vt[14] = '{1,  16'h0001,  1, -1};
`endif

      for (int i = 0; i < 15; i++) begin
         wcfg(0, vt[i].b);
         en = 1'b1;
         push_word(vt[i].d);
         wait_pt(w);
         if (i == 0) chk("first_latency", w, 2);
         chk("vec_bin", bin_num, 0);
         chk("vec_x", int'(x), vt[i].ex);
         chk("vec_y", int'(y), vt[i].ey);
         ack = 1'b1; tick(); ack = 1'b0;
         if (i == 0) chk("ack_clears_ready", xy_rdy, 0);
      end

      // bins 0..3 = 2,0,4,0; hold on bin0, then bin2 follows with bin1 skipped
      wcfg(0, 2); wcfg(1, 0); wcfg(2, 4); wcfg(3, 0);
      en = 1'b1;
      push_word(16'h00B3);
      wait_pt(w);
      chk("seq1_bin0", bin_num, 0);
      chk("seq1_x0", int'(x), -1);
      chk("seq1_y0", int'(y), -1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (xy_rdy !== 1'b1 || x !== -9'sd1 || y !== -9'sd1 || bin_num !== 8'd0 || in_rdy !== 1'b1) bad++;
      end
      chk("hold_stable", bad, 0);
      ack = 1'b1; tick(); ack = 1'b0;
      wait_pt(w);
      chk("seq1_bin2", bin_num, 2);
      chk("seq1_x2", int'(x), -3);
      chk("seq1_y2", int'(y), -3);

      // disable while holding bin2, then restart from bin0 with an empty buffer
      en = 1'b0; tick();
      chk("dis_xy_ready", xy_rdy, 0);
      chk("dis_in_ready", in_rdy, 1);
      chk("dis_sym_done", sd, 0);
      chk("dis_bin", bin_num, 0);
      en = 1'b1;
      push_word(16'h0003);
      wait_pt(w);
      chk("restart_bin", bin_num, 0);
      chk("restart_x", int'(x), -1);
      chk("restart_y", int'(y), -1);
      ack = 1'b1; tick(); ack = 1'b0;

      // table write attempted while enabled must not land
      wcfg(0, 2);
      en = 1'b1; we_conf = 1'b1; conf_addr = 8'd0; conf_data = 4'd4;
      tick();
      we_conf = 1'b0;
      push_word(16'h000C);
      wait_pt(w);
      chk("en_write_x", int'(x), 1);
      chk("en_write_y", int'(y), 1);

      // reset while holding a point
      reset = 1'b1; tick();
      chk("mid_rst_ready", xy_rdy, 0);
      chk("mid_rst_x", int'(x), 0);
      chk("mid_rst_bin", bin_num, 0);
      chk("mid_rst_in_ready", in_rdy, 1);
      reset = 1'b0; en = 1'b0; tick();

      // 4-bin instance: all b=2, two words, ack held high
      for (int i = 0; i < 4; i++) begin
         s_we_conf = 1'b1; s_conf_addr = 2'(i); s_conf_data = 4'd2;
         tick();
      end
      s_we_conf = 1'b0;
      stream = {16'h1B1B, 16'hE4E4};
      s_en = 1'b1; s_ack = 1'b1; s_we_data = 1'b1; s_data = 16'hE4E4;
      tick();
      s_we_data = 1'b0;
      n = 0; sd_bad = 0; sd_seen = 0; t_first = 0; t_last = 0; since_pt = 0;
      pend_sd = 0; words_left = 1;
      for (int c = 0; c < 300 && (n < 16 || pend_sd); c++) begin
         if (s_sd !== pend_sd) sd_bad++;
         if (s_sd) sd_seen++;
         pend_sd = 0;
         if (s_xy_rdy) begin
            v0 = stream[2*n];
            v1 = stream[2*n+1];
            chk("small_bin", s_bin_num, n % 4);
            chk("small_x", int'(s_x), v1 ? -1 : 1);
            chk("small_y", int'(s_y), v0 ? -1 : 1);
            if (n == 0) t_first = cyc;
            t_last = cyc;
            pend_sd = (n % 4 == 3);
            n++;
            since_pt = 0;
         end else begin
            since_pt++;
         end
         s_we_data = 1'b0;
         if (words_left && n > 0 && since_pt == 2 && s_in_rdy) begin
            s_we_data = 1'b1; s_data = 16'h1B1B; words_left = 0;
         end
         tick();
      end
      s_we_data = 1'b0;
      chk("small_points", n, 16);
      chk("small_span", t_last - t_first, 45);
      chk("sym_done_timing", sd_bad, 0);
      chk("sym_done_count", sd_seen, 4);
      for (int i = 0; i < 8; i++) tick();
      chk("small_starved", s_xy_rdy, 0);
      s_en = 1'b0; s_ack = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
